// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b computed LSB first through one
// full-adder cell with b inverted and the carry seeded to 1. Start/busy/done
// handshake; results are registered and hold until the next completion.
// Optional signed-overflow output is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sr_q, a_sr_d;
  logic [WIDTH-1:0]  b_sr_q, b_sr_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              c_q, c_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              zero_q, zero_d;
`ifdef SERIAL_SUB_OVF_EN
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              ovf_q, ovf_d;
`endif

  // Full-adder cell shared by every bit position
  logic             sum_bit;
  logic             c_next;
  logic [WIDTH-1:0] r_next;

  always_comb begin
    sum_bit = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    c_next  = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
    r_next  = {sum_bit, r_q[WIDTH-1:1]};
  end

  // Next-state and output-register logic for the IDLE/SHIFT/DONE sequence
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_d      = r_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = ~b;
          r_d     = '0;
          c_d     = 1'b1;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      StShift: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        r_d    = r_next;
        c_d    = c_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          diff_d   = r_next;
          borrow_d = ~c_next;
          zero_d   = (r_next == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StDone;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (r_next[WIDTH-1] != a_msb_q);
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      r_q      <= r_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Every output comes straight from a flop
  always_comb begin
    busy   = busy_q;
    done   = done_q;
    diff   = diff_q;
    borrow = borrow_q;
    zero   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf    = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus randomized bench for serial_subtractor (WIDTH=8). Expected
// results come from plain integer arithmetic on the operands.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
`ifdef SERIAL_SUB_OVF_EN
    .ovf    (ovf),
`endif
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one subtraction and check latency plus all results against the model.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    int     lat;
    int     sa, sb, sd;
    logic [W-1:0] exp_diff;
    lat = 0;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);  // operands may change after accept
    for (int n = 1; n <= 3 * W; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(W));
    exp_diff = W'(32'(ta) - 32'(tb_v));
    check({tag, "_diff"}, 32'(diff), 32'(exp_diff));
    check({tag, "_borrow"}, 32'(borrow), 32'(ta < tb_v));
    check({tag, "_zero"}, 32'(zero), 32'(ta == tb_v));
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    sa = int'($signed(ta));
    sb = int'($signed(tb_v));
    sd = sa - sb;
    check({tag, "_ovf"}, 32'(ovf), 32'((sd > 127) || (sd < -128)));
`else
    sa = 0; sb = 0; sd = 0;
`endif
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int first_done;
    int n_done;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("d11_4", 8'd11, 8'd4);
    do_op("d4_11", 8'd4, 8'd11);
    do_op("d55_55", 8'h55, 8'h55);
    do_op("d80_01", 8'h80, 8'h01);
    do_op("d10_01", 8'h10, 8'h01);
    do_op("d00_ff", 8'h00, 8'hFF);
    do_op("dff_00", 8'hFF, 8'h00);
    do_op("d7f_ff", 8'h7F, 8'hFF);

    // Second start during SHIFT must be ignored
    @(negedge clk);
    a = 8'h20; b = 8'h03; start = 1'b1;
    @(posedge clk);
    first_done = 0; n_done = 0;
    for (int k = 1; k <= 2 * W; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (k == 3) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    check("ign_done_count", 32'(n_done), 32'd1);
    check("ign_latency", 32'(first_done), 32'(W));
    check("ign_diff", 32'(diff), 32'h1D);
    check("ign_zero", 32'(zero), 32'd0);

    // Reset mid-operation aborts with no done
    @(negedge clk);
    a = 8'h40; b = 8'h01; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    check("abort_zero", 32'(zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    do_op("d9_9", 8'd9, 8'd9);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      do_op("rnd", W'($urandom), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
